// File: rtl/seg_readback.sv
// rtl/seg_readback.sv - two-digit seven-segment display readback with stability filter
//
// Samples a two-digit active-low seven-segment display, waits for a pattern to
// hold for STABLE_CYCLES samples, decodes it to a value 0..99 and presents it
// on a valid/ready output with the time since the previous value.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   seg0       in   ones digit, active-low, [7:1]=a..g, [0]=dp (ignored)
//   seg1       in   tens digit, same encoding as seg0
//   out_valid  out  a decoded value is held
//   out_ready  in   consumer accepts the held value
//   out_data   out  decoded value 0..99
//   out_period out  clk cycles since the previous loaded value (0 for the first)
//   seq_err    out  1-cycle pulse: loaded value is not previous+1 mod 100
//   pat_err    out  1-cycle pulse: accepted pattern could not be decoded
//   blank      out  level: last accepted pattern had both digits dark
//   overrun    out  sticky: a held, unconsumed value was overwritten

module seg_readback #(
  parameter int STABLE_CYCLES = 4,
  parameter int PW            = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    seg0,
  input  logic [7:0]    seg1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [6:0]    out_data,
  output logic [PW-1:0] out_period,
  output logic          seq_err,
  output logic          pat_err,
  output logic          blank,
  output logic          overrun
);

  localparam logic [3:0]    STABLE  = 4'(STABLE_CYCLES);
  localparam logic [PW-1:0] PER_ONE = PW'(1);
  localparam logic [PW-1:0] PER_MAX = '1;

  typedef enum logic {
    WAIT_FIRST,
    RUN
  } state_t;

  // Decode one digit byte into {decodable, dark, digit}. Only bits [7:1]
  // carry segments; the decimal point is ignored.
  function automatic logic [5:0] dec_digit(input logic [7:0] b);
    logic [5:0] r;
    case (b[7:1])
      7'h01:   r = {2'b10, 4'd0};
      7'h4F:   r = {2'b10, 4'd1};
      7'h12:   r = {2'b10, 4'd2};
      7'h06:   r = {2'b10, 4'd3};
      7'h4C:   r = {2'b10, 4'd4};
      7'h24:   r = {2'b10, 4'd5};
      7'h20:   r = {2'b10, 4'd6};
      7'h0F:   r = {2'b10, 4'd7};
      7'h00:   r = {2'b10, 4'd8};
      7'h0C:   r = {2'b10, 4'd9};
      7'h7F:   r = {2'b11, 4'd0};
      default: r = {2'b00, 4'd0};
    endcase
    return r;
  endfunction

  state_t        state;
  logic [15:0]   samp;
  logic [3:0]    cnt;
  logic          acc;
  logic [PW-1:0] per_cnt;

  logic [3:0] cnt_next;
  logic [5:0] d1;
  logic [5:0] d0;
  logic       both_dark;
  logic       pat_bad;
  logic [6:0] value;
  logic [6:0] succ;
  logic       is_dup;
  logic       do_load;

  always_comb begin
    cnt_next = cnt;
    if ({seg1, seg0} != samp) begin
      cnt_next = 4'd1;
    end else if (cnt != STABLE) begin
      cnt_next = cnt + 4'd1;
    end
  end

  // Decode whatever is in the sample register; it is only acted on while acc
  // is high, i.e. the cycle after the pattern completed its stable run.
  always_comb begin
    d1        = dec_digit(samp[15:8]);
    d0        = dec_digit(samp[7:0]);
    both_dark = d1[4] & d0[4];
    pat_bad   = !d1[5] || !d0[5] || (d1[4] ^ d0[4]);
    value     = ({3'b000, d1[3:0]} * 7'd10) + {3'b000, d0[3:0]};
    succ      = (out_data == 7'd99) ? 7'd0 : out_data + 7'd1;
    is_dup    = (state == RUN) && (value == out_data);
    do_load   = acc && !pat_bad && !both_dark && !is_dup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_FIRST;
      samp       <= 16'hFFFF;
      cnt        <= 4'd0;
      acc        <= 1'b0;
      per_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= 7'd0;
      out_period <= '0;
      seq_err    <= 1'b0;
      pat_err    <= 1'b0;
      blank      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      samp    <= {seg1, seg0};
      cnt     <= cnt_next;
      // One accept per run: only on the transition into the saturated count.
      acc     <= (cnt != STABLE) && (cnt_next == STABLE);
      seq_err <= 1'b0;
      pat_err <= 1'b0;

      if (do_load) begin
        per_cnt <= PER_ONE;
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + PER_ONE;
      end

      if (acc) begin
        if (pat_bad) begin
          pat_err <= 1'b1;
        end else if (both_dark) begin
          blank <= 1'b1;
          state <= WAIT_FIRST;
        end else begin
          blank <= 1'b0;
        end
      end

      if (do_load) begin
        out_data   <= value;
        out_valid  <= 1'b1;
        out_period <= (state == RUN) ? per_cnt : '0;
        seq_err    <= (state == RUN) && (value != succ);
        state      <= RUN;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_readback.sv
// tb/tb_seg_readback.sv - randomized self-checking bench for seg_readback

module tb_seg_readback;

  localparam int S  = 4;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    seg0;
  logic [7:0]    seg1;
  logic          out_valid;
  logic          out_ready;
  logic [6:0]    out_data;
  logic [PW-1:0] out_period;
  logic          seq_err;
  logic          pat_err;
  logic          blank;
  logic          overrun;

  seg_readback #(.STABLE_CYCLES(S), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg0       (seg0),
    .seg1       (seg1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_period (out_period),
    .seq_err    (seq_err),
    .pat_err    (pat_err),
    .blank      (blank),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] seg_tab [10] = '{8'h02, 8'h9E, 8'h24, 8'h0C, 8'h98,
                               8'h48, 8'h40, 8'h1E, 8'h00, 8'h18};

  // 0..9 digit, 10 dark, -1 undecodable
  function automatic int dec(input logic [7:0] b);
    if ((b | 8'h01) == 8'hFF) return 10;
    for (int i = 0; i < 10; i++) begin
      if ((b & 8'hFE) == seg_tab[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] enc(input int v, input logic dp1, input logic dp0);
    return {seg_tab[v / 10] | {7'b0, dp1}, seg_tab[v % 10] | {7'b0, dp0}};
  endfunction

  // Reference model: events keyed on edge numbers, not on RTL registers.
  bit          m_valid, m_seq, m_pat, m_blank, m_over, m_run;
  int          m_data, m_period;
  int          run_len;
  logic [15:0] prev_in;
  bit          acc_pend;
  logic [15:0] acc_pat;
  int          edge_idx;
  int          last_load;

  task automatic model_edge(input logic [15:0] pat, input bit rdy, input bit r);
    int  t, o, v;
    bit  loaded;
    edge_idx++;
    if (r) begin
      m_valid = 0; m_seq = 0; m_pat = 0; m_blank = 0; m_over = 0; m_run = 0;
      m_data = 0; m_period = 0; run_len = 0; acc_pend = 0;
      return;
    end
    m_seq  = 0;
    m_pat  = 0;
    loaded = 0;
    if (acc_pend) begin
      t = dec(acc_pat[15:8]);
      o = dec(acc_pat[7:0]);
      if (t < 0 || o < 0 || ((t == 10) != (o == 10))) begin
        m_pat = 1;
      end else if (t == 10) begin
        m_blank = 1;
        m_run   = 0;
      end else begin
        v = t * 10 + o;
        m_blank = 0;
        if (!(m_run && v == m_data)) begin
          loaded = 1;
          if (m_valid && !rdy) m_over = 1;
          m_seq     = m_run && (v != (m_data + 1) % 100);
          m_period  = m_run ? (edge_idx - last_load) : 0;
          last_load = edge_idx;
          m_data    = v;
          m_valid   = 1;
          m_run     = 1;
        end
      end
    end
    if (!loaded && m_valid && rdy) m_valid = 0;
    // A pattern is accepted once, when it has been sampled S times in a row.
    if (run_len == 0 || pat != prev_in) run_len = 1;
    else if (run_len < S + 1) run_len++;
    prev_in  = pat;
    acc_pend = (run_len == S);
    acc_pat  = pat;
  endtask

  task automatic cyc(input logic [15:0] pat, input bit rdy, input bit r);
    seg1      = pat[15:8];
    seg0      = pat[7:0];
    out_ready = rdy;
    rst       = r;
    @(posedge clk);
    model_edge(pat, rdy, r);
    #1;
    check("out_valid",  32'(out_valid),  32'(m_valid));
    check("out_data",   32'(out_data),   32'(m_data));
    check("out_period", 32'(out_period), 32'(m_period));
    check("seq_err",    32'(seq_err),    32'(m_seq));
    check("pat_err",    32'(pat_err),    32'(m_pat));
    check("blank",      32'(blank),      32'(m_blank));
    check("overrun",    32'(overrun),    32'(m_over));
  endtask

  // rdy_mode: 0 never ready, 1 always ready, 2 random
  task automatic hold(input logic [15:0] pat, input int n, input int rdy_mode);
    bit rdy;
    for (int i = 0; i < n; i++) begin
      rdy = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
      cyc(pat, rdy, 1'b0);
    end
  endtask

  initial begin
    int cur, kind, nv, dur, rmode;
    logic [15:0] p;
    edge_idx  = 0;
    last_load = 0;
    prev_in   = 16'hFFFF;
    acc_pat   = 16'hFFFF;
    cyc(16'hFFFF, 1'b1, 1'b1);
    cyc(16'hFFFF, 1'b1, 1'b1);

    hold(enc(1, 0, 0), 6, 1);
    hold(enc(2, 0, 0), 10, 1);
    hold(enc(3, 0, 0), 10, 1);
    hold(enc(99, 0, 0), 8, 1);
    hold(enc(0, 0, 0), 8, 1);
    hold(enc(5, 0, 0), 8, 1);
    hold(enc(7, 0, 0), 8, 1);
    hold({seg_tab[0], 8'h24}, 3, 1);
    hold(enc(7, 0, 0), 8, 1);
    hold(enc(10, 0, 0), 8, 0);
    hold(enc(11, 0, 0), 8, 0);
    hold(enc(11, 0, 0), 3, 1);
    hold(enc(12, 0, 0), 2, 1);
    cyc(enc(12, 0, 0), 1'b1, 1'b1);
    hold(enc(40, 0, 0), 8, 1);
    hold({seg_tab[4], 8'h66}, 8, 1);
    hold({8'hFF, seg_tab[3]}, 8, 1);
    hold(16'hFFFF, 8, 1);
    hold(enc(41, 1, 1), 8, 1);
    hold(enc(42, 0, 1), 1, 1);
    hold(enc(42, 0, 1), 2, 1);
    hold(enc(42, 0, 1), 6, 1);

    cur = 42;
    for (int h = 0; h < 320; h++) begin
      kind  = $urandom_range(0, 19);
      dur   = $urandom_range(1, 12);
      rmode = $urandom_range(0, 2);
      if (kind == 0) begin
        p = {7'h7F, 1'($urandom_range(0, 1)), 7'h7F, 1'($urandom_range(0, 1))};
      end else if (kind == 1) begin
        p = {8'($urandom_range(0, 255)), seg_tab[$urandom_range(0, 9)]};
      end else if (kind == 2) begin
        p = {seg_tab[$urandom_range(0, 9)], 8'hFF};
      end else if (kind == 3) begin
        cyc(enc(cur, 0, 0), 1'b1, 1'b1);
        continue;
      end else begin
        nv  = (kind < 6) ? $urandom_range(0, 99) : (cur + 1) % 100;
        cur = nv;
        p   = enc(nv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      hold(p, dur, rmode);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
